// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART loopback self-test engine.
package uart_pkg;

  typedef enum logic [1:0] {
    PAT_INCR  = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_WALK1 = 2'd2,
    PAT_ALT   = 2'd3
  } pattern_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_CHECK   = 3'd4,
    ST_FINISH  = 3'd5
  } bist_state_e;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] data_mask(input logic [3:0] data_bits);
    logic [7:0] m;
    case (data_bits)
      4'd5:    m = 8'h1F;
      4'd6:    m = 8'h3F;
      4'd7:    m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // XNOR feedback gives the A5 -> 4B -> 96 sequence; all-ones is the lock-up value.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ~^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/uart_pattern_gen.sv
// Registered byte-pattern generator: reseeds on load, steps on advance.
module uart_pattern_gen
  import uart_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] pattern
);

  pattern_mode_e mode_q, mode_d;
  logic [7:0]    pat_q, pat_d;

  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    if (load) begin
      mode_d = pattern_mode_e'(mode);
      case (pattern_mode_e'(mode))
        PAT_INCR:  pat_d = 8'h00;
        PAT_LFSR:  pat_d = LFSR_SEED;
        PAT_WALK1: pat_d = 8'h01;
        PAT_ALT:   pat_d = 8'hA5;
        default:   pat_d = 8'h00;
      endcase
    end else if (advance) begin
      case (mode_q)
        PAT_INCR:  pat_d = pat_q + 8'd1;
        PAT_LFSR:  pat_d = lfsr_step(pat_q);
        PAT_WALK1: pat_d = {pat_q[6:0], pat_q[7]};
        PAT_ALT:   pat_d = ~pat_q;
        default:   pat_d = pat_q;
      endcase
    end else begin
      mode_d = mode_q;
      pat_d  = pat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= PAT_LFSR;
      pat_q  <= LFSR_SEED;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
    end
  end

  assign pattern = pat_q;

endmodule

// File: rtl/uart_loopback_bist.sv
// Loopback self-test engine: drives uart_tx with a pattern stream and checks the
// bytes coming back from uart_rx, counting failures and capturing the first one.
module uart_loopback_bist
  import uart_pkg::*;
#(
  parameter int         MAX_BYTES      = 256,
  parameter int         TIMEOUT_CYCLES = 40000,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         ERR_W          = 16,
  localparam int        CW             = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    byte_count,
  input  logic [3:0]       data_bits,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic [7:0]       rx_data,
  input  logic             data_ready,
  input  logic             parity_err,
  input  logic             framing_err,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             timeout_seen,
  output logic [CW-1:0]    first_err_idx,
  output logic [7:0]       first_err_exp,
  output logic [7:0]       first_err_got
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  bist_state_e      state_q, state_d;
  logic [CW-1:0]    byte_count_q, byte_count_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [7:0]       mask_q, mask_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             timeout_seen_q, timeout_seen_d;
  logic [CW-1:0]    first_err_idx_q, first_err_idx_d;
  logic [7:0]       first_err_exp_q, first_err_exp_d;
  logic [7:0]       first_err_got_q, first_err_got_d;
  logic             byte_err_q, byte_err_d;
  logic [7:0]       got_q, got_d;
  logic             gen_load, gen_adv;
  logic [7:0]       gen_pattern;

  uart_pattern_gen #(.LFSR_SEED(LFSR_SEED)) u_gen (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .load    (gen_load),
    .advance (gen_adv),
    .pattern (gen_pattern)
  );

  always_comb begin
    state_d         = state_q;
    byte_count_d    = byte_count_q;
    idx_d           = idx_q;
    mask_d          = mask_q;
    tmo_d           = tmo_q;
    tx_data_d       = tx_data_q;
    tx_start_d      = 1'b0;
    busy_d          = busy_q;
    done_d          = 1'b0;
    pass_d          = pass_q;
    err_count_d     = err_count_q;
    timeout_seen_d  = timeout_seen_q;
    first_err_idx_d = first_err_idx_q;
    first_err_exp_d = first_err_exp_q;
    first_err_got_d = first_err_got_q;
    byte_err_d      = byte_err_q;
    got_d           = got_q;
    gen_load        = 1'b0;
    gen_adv         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start landing on the done cycle belongs to the finished run.
        if (start && !done_q) begin
          byte_count_d    = byte_count;
          mask_d          = data_mask(data_bits);
          idx_d           = {CW{1'b0}};
          err_count_d     = {ERR_W{1'b0}};
          timeout_seen_d  = 1'b0;
          first_err_idx_d = {CW{1'b0}};
          first_err_exp_d = 8'h00;
          first_err_got_d = 8'h00;
          pass_d          = 1'b0;
          busy_d          = 1'b1;
          gen_load        = 1'b1;
          state_d         = (byte_count == {CW{1'b0}}) ? ST_FINISH : ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!tx_busy) begin
          tx_data_d = gen_pattern & mask_q;
          state_d   = ST_SEND;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SEND: begin
        tx_start_d = 1'b1;
        tmo_d      = {TW{1'b0}};
        state_d    = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        if (data_ready) begin
          byte_err_d = parity_err | framing_err |
                       (((rx_data ^ tx_data_q) & mask_q) != 8'h00);
          got_d      = rx_data;
          state_d    = ST_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          byte_err_d     = 1'b1;
          got_d          = 8'h00;
          timeout_seen_d = 1'b1;
          state_d        = ST_CHECK;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_CHECK: begin
        gen_adv = 1'b1;
        if (byte_err_q) begin
          err_count_d = (err_count_q == {ERR_W{1'b1}}) ? err_count_q
                                                       : err_count_q + ERR_W'(1);
          if (err_count_q == {ERR_W{1'b0}}) begin
            first_err_idx_d = idx_q;
            first_err_exp_d = tx_data_q;
            first_err_got_d = got_q;
          end else begin
            first_err_idx_d = first_err_idx_q;
          end
        end else begin
          err_count_d = err_count_q;
        end
        idx_d   = idx_q + CW'(1);
        state_d = (idx_d == byte_count_q) ? ST_FINISH : ST_LOAD;
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        pass_d  = (err_count_q == {ERR_W{1'b0}});
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      byte_count_q    <= {CW{1'b0}};
      idx_q           <= {CW{1'b0}};
      mask_q          <= 8'hFF;
      tmo_q           <= {TW{1'b0}};
      tx_data_q       <= 8'h00;
      tx_start_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= {ERR_W{1'b0}};
      timeout_seen_q  <= 1'b0;
      first_err_idx_q <= {CW{1'b0}};
      first_err_exp_q <= 8'h00;
      first_err_got_q <= 8'h00;
      byte_err_q      <= 1'b0;
      got_q           <= 8'h00;
    end else begin
      state_q         <= state_d;
      byte_count_q    <= byte_count_d;
      idx_q           <= idx_d;
      mask_q          <= mask_d;
      tmo_q           <= tmo_d;
      tx_data_q       <= tx_data_d;
      tx_start_q      <= tx_start_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_count_q     <= err_count_d;
      timeout_seen_q  <= timeout_seen_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_exp_q <= first_err_exp_d;
      first_err_got_q <= first_err_got_d;
      byte_err_q      <= byte_err_d;
      got_q           <= got_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign timeout_seen  = timeout_seen_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_exp = first_err_exp_q;
  assign first_err_got = first_err_got_q;

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Bench for uart_loopback_bist with a behavioural UART loopback responder that can
// flip a bit, raise parity_err, or drop the link entirely.
module tb_uart_loopback_bist;

  localparam int CW   = 9;
  localparam int TMO  = 300;
  localparam int LAT  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [CW-1:0] byte_count = '0;
  logic [3:0]  data_bits = 4'd8;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        data_ready = 1'b0;
  logic        parity_err = 1'b0;
  logic        framing_err = 1'b0;
  logic        busy, done, pass, timeout_seen;
  logic [15:0] err_count;
  logic [CW-1:0] first_err_idx;
  logic [7:0]  first_err_exp, first_err_got;

  int fault_kind = 0;  // 0 none, 1 flip bit0, 2 parity error, 3 link broken
  int fault_idx  = 0;
  int rsp_cnt = 0;
  int byte_no = 0;
  logic rsp_act = 1'b0;
  logic [7:0] rsp_byte = 8'h00;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0]      mode;
    int              count;
    logic [3:0]      dbits;
    int              fkind;
    int              fidx;
    logic [3:0][7:0] tx;
    int              err;
    logic            pass;
    logic            tmo;
    int              fe_idx;
    logic [7:0]      fe_exp;
    logic [7:0]      fe_got;
  } vec_t;

  vec_t vecs[7];

  uart_loopback_bist #(
    .MAX_BYTES(256), .TIMEOUT_CYCLES(TMO), .LFSR_SEED(8'hA5), .ERR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .byte_count(byte_count),
    .data_bits(data_bits), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .data_ready(data_ready), .parity_err(parity_err),
    .framing_err(framing_err), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .timeout_seen(timeout_seen), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tb_mask(input logic [3:0] db);
    logic [7:0] ff;
    ff = 8'hFF;
    return ff >> (4'd8 - db);
  endfunction

  // Loopback responder: echoes each transmitted byte LAT cycles after tx_start.
  always @(posedge clk) begin
    data_ready  <= 1'b0;
    parity_err  <= 1'b0;
    framing_err <= 1'b0;
    if (rst) begin
      rsp_act <= 1'b0;
      rsp_cnt <= 0;
      tx_busy <= 1'b0;
      byte_no <= 0;
      rx_data <= 8'h00;
    end else begin
      if (start && !busy) byte_no <= 0;
      if (tx_start) begin
        rsp_act  <= 1'b1;
        rsp_cnt  <= 0;
        tx_busy  <= 1'b1;
        rsp_byte <= tx_data;
      end else if (rsp_act) begin
        rsp_cnt <= rsp_cnt + 1;
        if (rsp_cnt == 12) tx_busy <= 1'b0;
        if (rsp_cnt == LAT) begin
          rsp_act <= 1'b0;
          byte_no <= byte_no + 1;
          if (fault_kind != 3) begin
            data_ready <= 1'b1;
            rx_data <= (rsp_byte ^ ((fault_kind == 1 && byte_no == fault_idx) ? 8'h01 : 8'h00))
                       | ~tb_mask(data_bits);
            parity_err <= (fault_kind == 2 && byte_no == fault_idx);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One negedge step; also the scoreboard pop for every tx_start pulse.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    if (tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", {24'h0, tx_data}, {24'h0, e});
      end
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input int cnt, input logic [3:0] db,
                              input int fk, input int fi, input logic [31:0] tx,
                              input int err, input logic ps, input logic tmo,
                              input int fei, input logic [7:0] fee, input logic [7:0] feg);
    vec_t v;
    v.mode = m; v.count = cnt; v.dbits = db; v.fkind = fk; v.fidx = fi; v.tx = tx;
    v.err = err; v.pass = ps; v.tmo = tmo; v.fe_idx = fei; v.fe_exp = fee; v.fe_got = feg;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    int  cyc;
    bit  poked;
    string tag;
    tag = $sformatf("v%0d_", n);
    mode = v.mode; byte_count = CW'(v.count); data_bits = v.dbits;
    fault_kind = v.fkind; fault_idx = v.fidx;
    for (int i = 0; i < v.count; i++) exp_q.push_back(v.tx[i]);
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0; poked = 1'b0;
    while (done_cnt == 0 && cyc < 5000) begin
      if (!poked && exp_q.size() < v.count) begin
        start = 1'b1;   // start mid-run must be ignored
        step();
        start = 1'b0;
        poked = 1'b1;
      end else begin
        step();
      end
      cyc++;
    end
    repeat (3) step();
    check({tag, "done_once"}, done_cnt, 1);
    check({tag, "busy_idle"}, {31'h0, busy}, 0);
    check({tag, "tx_left"}, exp_q.size(), 0);
    check({tag, "err_count"}, {16'h0, err_count}, v.err);
    check({tag, "pass"}, {31'h0, pass}, {31'h0, v.pass});
    check({tag, "timeout_seen"}, {31'h0, timeout_seen}, {31'h0, v.tmo});
    if (v.err != 0) begin
      check({tag, "first_idx"}, {23'h0, first_err_idx}, v.fe_idx);
      check({tag, "first_exp"}, {24'h0, first_err_exp}, {24'h0, v.fe_exp});
      check({tag, "first_got"}, {24'h0, first_err_got}, {24'h0, v.fe_got});
    end else begin
      check({tag, "first_idx_clear"}, {23'h0, first_err_idx}, 0);
    end
    exp_q.delete();
    fault_kind = 0;
  endtask

  initial begin
    int lat;
    int k;
    vecs[0] = mk(2'd0, 4, 4'd8, 0, 0, 32'h03020100, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    vecs[1] = mk(2'd1, 3, 4'd8, 0, 0, 32'h00964BA5, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    vecs[2] = mk(2'd3, 2, 4'd5, 0, 0, 32'h00001A05, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    vecs[3] = mk(2'd0, 4, 4'd8, 1, 2, 32'h03020100, 1, 1'b0, 1'b0, 2, 8'h02, 8'h03);
    vecs[4] = mk(2'd2, 4, 4'd8, 0, 0, 32'h08040201, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    vecs[5] = mk(2'd0, 2, 4'd8, 3, 0, 32'h00000100, 2, 1'b0, 1'b1, 0, 8'h00, 8'h00);
    vecs[6] = mk(2'd0, 2, 4'd8, 2, 1, 32'h00000100, 1, 1'b0, 1'b0, 1, 8'h01, 8'h01);

    rst = 1'b1;
    repeat (3) step();
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_pass", {31'h0, pass}, 0);
    check("rst_tx_start", {31'h0, tx_start}, 0);
    check("rst_err_count", {16'h0, err_count}, 0);
    check("rst_tx_data", {24'h0, tx_data}, 0);
    rst = 1'b0;
    step();

    // Latency to first tx_start, then reset while waiting for the lost byte.
    mode = 2'd0; byte_count = CW'(4); data_bits = 4'd8; fault_kind = 3;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (tx_start !== 1'b1 && lat < 50) begin
      step();
      lat++;
    end
    check("start_to_tx_start", lat, 3);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_tx_start", {31'h0, tx_start}, 0);
    check("abort_err_count", {16'h0, err_count}, 0);
    repeat (400) step();
    check("abort_no_done", done_cnt, 0);
    exp_q.delete();
    fault_kind = 0;

    // Zero-length run, plus a start landing on the done cycle.
    byte_count = '0;
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("zero_done_latency", k, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_on_done_ignored", {31'h0, busy}, 0);
    check("zero_pass", {31'h0, pass}, 1);
    repeat (3) step();
    check("zero_done_once", done_cnt, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
